// File: rtl/cache_miss_controller.sv
// Miss/refill sequencer between the CPU port, a 4-way cache array and main memory (write-through, no write-allocate).
// Define CACHE_PERF_CNT_EN to add saturating hit_count/miss_count outputs.
module cache_miss_controller #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [DATA_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ready,
   output logic                  cpu_err,
   output logic                  cpu_busy,
   output logic [DATA_WIDTH-1:0] cache_addr,
   output logic [DATA_WIDTH-1:0] cache_wdata,
   output logic                  cache_we,
   input  logic [DATA_WIDTH-1:0] cache_rdata,
   input  logic                  cache_hit,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack
`ifdef CACHE_PERF_CNT_EN
   ,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
`endif
);

   localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_MEM_RD,
      S_FILL,
      S_MEM_WR,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   addr_q, addr_d;
   logic                    we_q, we_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0]   fill_q, fill_d;
   logic                    err_q, err_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    tmo_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         fill_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         fill_q  <= fill_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // The limit is reached in the cycle where the count would become MEM_TIMEOUT; an ack that cycle wins.
   assign tmo_hit = (MEM_TIMEOUT != 0) && (cnt_q == TMO_LAST);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      fill_d      = fill_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      cache_we    = 1'b0;
      cache_wdata = '0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      cpu_ready   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               addr_d  = cpu_addr;
               we_d    = cpu_we;
               wdata_d = cpu_wdata;
               state_d = S_LOOKUP;
            end
         end

         S_LOOKUP: begin
            cnt_d = '0;
            if (we_q) begin
               cache_we    = cache_hit;
               cache_wdata = wdata_q;
               state_d     = S_MEM_WR;
            end else if (cache_hit) begin
               rdata_d = cache_rdata;
               state_d = S_DONE;
            end else begin
               state_d = S_MEM_RD;
            end
         end

         S_MEM_RD: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               fill_d  = mem_rdata;
               state_d = S_FILL;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_FILL: begin
            cache_we    = 1'b1;
            cache_wdata = fill_q;
            rdata_d     = fill_q;
            state_d     = S_DONE;
         end

         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ack) begin
               state_d = S_DONE;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_DONE: begin
            cpu_ready = 1'b1;
            err_d     = 1'b0;
            state_d   = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign cpu_rdata  = rdata_q;
   assign cpu_err    = err_q;
   assign cpu_busy   = (state_q != S_IDLE);
   assign cache_addr = addr_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;

`ifdef CACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == S_LOOKUP) begin
         if (cache_hit) begin
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
         end else begin
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_miss_controller.sv
// Directed bench for cache_miss_controller with a small behavioural cache array and a scripted memory responder.
module tb_cache_miss_controller;

   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_req, cpu_we;
   logic [DW-1:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic          cpu_ready, cpu_err, cpu_busy;
   logic [DW-1:0] cache_addr, cache_wdata, cache_rdata;
   logic          cache_we, cache_hit;
   logic          mem_req, mem_we, mem_ack;
   logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_PERF_CNT_EN
   logic [31:0]   hit_count, miss_count;
`endif

   always #5 clk = ~clk;

   cache_miss_controller #(
      .DATA_WIDTH (DW),
      .MEM_TIMEOUT(TMO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_ready  (cpu_ready),
      .cpu_err    (cpu_err),
      .cpu_busy   (cpu_busy),
      .cache_addr (cache_addr),
      .cache_wdata(cache_wdata),
      .cache_we   (cache_we),
      .cache_rdata(cache_rdata),
      .cache_hit  (cache_hit),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
`ifdef CACHE_PERF_CNT_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   // Behavioural 4-entry cache: combinational lookup, round-robin allocation on writes to new addresses.
   logic [DW-1:0] c_tag [4];
   logic [DW-1:0] c_dat [4];
   logic [3:0]    c_val;
   logic [1:0]    c_ptr;
   logic          cl_en, pl_en;
   logic [DW-1:0] pl_addr, pl_data;
   logic [DW-1:0] w_addr, w_data;
   logic          w_en, w_match;
   logic [1:0]    w_slot;

   always_comb begin
      cache_hit   = 1'b0;
      cache_rdata = '0;
      for (int i = 0; i < 4; i++)
         if (c_val[i] && c_tag[i] == cache_addr) begin
            cache_hit   = 1'b1;
            cache_rdata = c_dat[i];
         end
   end

   always_comb begin
      w_en    = pl_en | cache_we;
      w_addr  = pl_en ? pl_addr : cache_addr;
      w_data  = pl_en ? pl_data : cache_wdata;
      w_slot  = c_ptr;
      w_match = 1'b0;
      for (int i = 0; i < 4; i++)
         if (c_val[i] && c_tag[i] == w_addr) begin
            w_slot  = 2'(i);
            w_match = 1'b1;
         end
   end

   always @(posedge clk) begin
      if (cl_en) begin
         c_val <= '0;
         c_ptr <= '0;
      end else if (w_en) begin
         c_tag[w_slot] <= w_addr;
         c_dat[w_slot] <= w_data;
         c_val[w_slot] <= 1'b1;
         if (!w_match) c_ptr <= c_ptr + 2'd1;
      end
   end

   int vec_cnt = 0;
   int err_cnt = 0;

   int            r_lat, r_req, r_cwe, r_cwe_first;
   logic [DW-1:0] r_rdata, r_cwdata, r_maddr, r_mwdata;
   logic          r_err, r_mwe;

   task automatic preload(input logic [DW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      @(negedge clk);
      pl_en   = 1'b0;
   endtask

   // Issue one access; memory acks on the ack_lat-th mem_req cycle (0 = never). Cycle 1 follows the sampling edge.
   task automatic run_access(input logic we, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                             input int ack_lat, input logic [DW-1:0] ack_data);
      r_lat = -1; r_req = 0; r_cwe = 0; r_cwe_first = -1;
      r_rdata = '0; r_cwdata = '0; r_maddr = '0; r_mwdata = '0; r_err = 1'b0; r_mwe = 1'b0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      @(posedge clk);
      #1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      for (int cyc = 1; cyc <= 100 && r_lat < 0; cyc++) begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (mem_req) begin
            r_req++;
            r_maddr  = mem_addr;
            r_mwdata = mem_wdata;
            r_mwe    = mem_we;
            if (r_req == ack_lat) begin
               mem_ack   = 1'b1;
               mem_rdata = ack_data;
            end
         end
         if (cache_we) begin
            r_cwe++;
            r_cwdata = cache_wdata;
            if (r_cwe_first < 0) r_cwe_first = cyc;
         end
         if (cpu_ready) begin
            r_lat   = cyc;
            r_rdata = cpu_rdata;
            r_err   = cpu_err;
         end
      end
      mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cl_en = 1'b1;
      repeat (2) @(negedge clk);
      cl_en = 1'b0;
      vec_cnt++; if (cpu_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_ready: got %b expected 0", cpu_ready); end
      vec_cnt++; if (cpu_busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b expected 0", cpu_busy); end
      vec_cnt++; if (mem_req !== 1'b0) begin err_cnt++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
      vec_cnt++; if (cache_we !== 1'b0) begin err_cnt++; $display("FAIL rst_cache_we: got %b expected 0", cache_we); end
      vec_cnt++; if (cpu_rdata !== 32'h0) begin err_cnt++; $display("FAIL rst_rdata: got %h expected 0", cpu_rdata); end
      vec_cnt++; if (cpu_err !== 1'b0) begin err_cnt++; $display("FAIL rst_err: got %b expected 0", cpu_err); end
      vec_cnt++; if (mem_addr !== 32'h0 || cache_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         err_cnt++; $display("FAIL rst_latches: got %h/%h/%h expected 0", mem_addr, cache_addr, mem_wdata); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_load_hit();
      preload(32'h40, 32'hDEADBEEF);
      run_access(1'b0, 32'h40, 32'h0, 1, 32'h0);
      vec_cnt++; if (r_lat !== 2) begin err_cnt++; $display("FAIL hit_lat: got %0d expected 2", r_lat); end
      vec_cnt++; if (r_rdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL hit_rdata: got %h expected deadbeef", r_rdata); end
      vec_cnt++; if (r_req !== 0) begin err_cnt++; $display("FAIL hit_memreq: got %0d cycles expected 0", r_req); end
      vec_cnt++; if (r_cwe !== 0) begin err_cnt++; $display("FAIL hit_cache_we: got %0d cycles expected 0", r_cwe); end
   endtask

   task automatic test_load_miss();
      run_access(1'b0, 32'h80, 32'h0, 3, 32'h12345678);
      vec_cnt++; if (r_lat !== 6) begin err_cnt++; $display("FAIL miss_lat: got %0d expected 6", r_lat); end
      vec_cnt++; if (r_rdata !== 32'h12345678) begin err_cnt++; $display("FAIL miss_rdata: got %h expected 12345678", r_rdata); end
      vec_cnt++; if (r_maddr !== 32'h80 || r_mwe !== 1'b0) begin
         err_cnt++; $display("FAIL miss_mem: got addr %h we %b expected 80/0", r_maddr, r_mwe); end
      vec_cnt++; if (r_req !== 3) begin err_cnt++; $display("FAIL miss_req_cycles: got %0d expected 3", r_req); end
      vec_cnt++; if (r_cwe !== 1 || r_cwe_first !== 5) begin
         err_cnt++; $display("FAIL miss_fill_we: got %0d pulses at cycle %0d expected 1 at 5", r_cwe, r_cwe_first); end
      vec_cnt++; if (r_cwdata !== 32'h12345678) begin err_cnt++; $display("FAIL miss_fill_data: got %h expected 12345678", r_cwdata); end
      vec_cnt++; if (r_err !== 1'b0) begin err_cnt++; $display("FAIL miss_err: got %b expected 0", r_err); end
      run_access(1'b0, 32'h80, 32'h0, 1, 32'hFFFFFFFF);
      vec_cnt++; if (r_lat !== 2 || r_rdata !== 32'h12345678) begin
         err_cnt++; $display("FAIL rehit: got lat %0d data %h expected 2/12345678", r_lat, r_rdata); end
   endtask

   task automatic test_store();
      run_access(1'b1, 32'h40, 32'hA5A5A5A5, 2, 32'h0);
      vec_cnt++; if (r_lat !== 4) begin err_cnt++; $display("FAIL st_hit_lat: got %0d expected 4", r_lat); end
      vec_cnt++; if (r_cwe !== 1 || r_cwe_first !== 1) begin
         err_cnt++; $display("FAIL st_hit_cache_we: got %0d pulses at cycle %0d expected 1 at 1", r_cwe, r_cwe_first); end
      vec_cnt++; if (r_cwdata !== 32'hA5A5A5A5) begin err_cnt++; $display("FAIL st_hit_cwdata: got %h expected a5a5a5a5", r_cwdata); end
      vec_cnt++; if (r_mwe !== 1'b1 || r_mwdata !== 32'hA5A5A5A5 || r_maddr !== 32'h40) begin
         err_cnt++; $display("FAIL st_hit_mem: got we %b data %h addr %h expected 1/a5a5a5a5/40", r_mwe, r_mwdata, r_maddr); end
      vec_cnt++; if (r_req !== 2) begin err_cnt++; $display("FAIL st_hit_req_cycles: got %0d expected 2", r_req); end
      run_access(1'b0, 32'h40, 32'h0, 1, 32'h0);
      vec_cnt++; if (r_lat !== 2 || r_rdata !== 32'hA5A5A5A5) begin
         err_cnt++; $display("FAIL st_update: got lat %0d data %h expected 2/a5a5a5a5", r_lat, r_rdata); end
      run_access(1'b1, 32'hC0, 32'h13572468, 1, 32'h0);
      vec_cnt++; if (r_lat !== 3) begin err_cnt++; $display("FAIL st_miss_lat: got %0d expected 3", r_lat); end
      vec_cnt++; if (r_cwe !== 0) begin err_cnt++; $display("FAIL st_miss_cache_we: got %0d pulses expected 0", r_cwe); end
      vec_cnt++; if (r_mwe !== 1'b1 || r_mwdata !== 32'h13572468 || r_maddr !== 32'hC0) begin
         err_cnt++; $display("FAIL st_miss_mem: got we %b data %h addr %h expected 1/13572468/c0", r_mwe, r_mwdata, r_maddr); end
      run_access(1'b0, 32'hC0, 32'h0, 2, 32'h0BADF00D);
      vec_cnt++; if (r_lat !== 5 || r_rdata !== 32'h0BADF00D) begin
         err_cnt++; $display("FAIL st_no_alloc: got lat %0d data %h expected 5/0badf00d", r_lat, r_rdata); end
   endtask

   task automatic test_timeout();
      run_access(1'b0, 32'h100, 32'h0, 0, 32'h0);
      vec_cnt++; if (r_req !== 4) begin err_cnt++; $display("FAIL tmo_req_cycles: got %0d expected 4", r_req); end
      vec_cnt++; if (r_lat !== 6) begin err_cnt++; $display("FAIL tmo_lat: got %0d expected 6", r_lat); end
      vec_cnt++; if (r_err !== 1'b1) begin err_cnt++; $display("FAIL tmo_err: got %b expected 1", r_err); end
      vec_cnt++; if (r_rdata !== 32'h0) begin err_cnt++; $display("FAIL tmo_rdata: got %h expected 0", r_rdata); end
      vec_cnt++; if (r_cwe !== 0) begin err_cnt++; $display("FAIL tmo_no_fill: got %0d pulses expected 0", r_cwe); end
      @(negedge clk);
      vec_cnt++; if (cpu_err !== 1'b0) begin err_cnt++; $display("FAIL tmo_err_clear: got %b expected 0", cpu_err); end
      run_access(1'b0, 32'h80, 32'h0, 1, 32'h0);
      vec_cnt++; if (r_lat !== 2 || r_err !== 1'b0 || r_rdata !== 32'h12345678) begin
         err_cnt++; $display("FAIL tmo_recover: got lat %0d err %b data %h expected 2/0/12345678", r_lat, r_err, r_rdata); end
   endtask

   task automatic test_ack_at_limit();
      run_access(1'b0, 32'h140, 32'h0, 4, 32'h55AA55AA);
      vec_cnt++; if (r_lat !== 7 || r_err !== 1'b0) begin
         err_cnt++; $display("FAIL limit_ack: got lat %0d err %b expected 7/0", r_lat, r_err); end
      vec_cnt++; if (r_rdata !== 32'h55AA55AA || r_cwe !== 1) begin
         err_cnt++; $display("FAIL limit_fill: got data %h fills %0d expected 55aa55aa/1", r_rdata, r_cwe); end
   endtask

   task automatic test_misc();
      repeat (3) @(negedge clk);
      vec_cnt++; if (cpu_rdata !== 32'h55AA55AA) begin err_cnt++; $display("FAIL rdata_hold: got %h expected 55aa55aa", cpu_rdata); end
      mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      mem_ack = 1'b0;
      vec_cnt++; if (cpu_busy !== 1'b0 || cpu_ready !== 1'b0 || cache_we !== 1'b0) begin
         err_cnt++; $display("FAIL idle_ack: got busy %b ready %b cwe %b expected 0/0/0", cpu_busy, cpu_ready, cache_we); end
   endtask

   task automatic test_reset_mid();
      int seen_ready;
      seen_ready = 0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h180;
      @(posedge clk);
      #1 cpu_req = 1'b0;
      repeat (2) @(negedge clk);
      vec_cnt++; if (mem_req !== 1'b1) begin err_cnt++; $display("FAIL rmid_pre_req: got %b expected 1", mem_req); end
      #2 rst_n = 1'b0;
      #1;
      vec_cnt++; if (mem_req !== 1'b0 || cpu_busy !== 1'b0 || cpu_ready !== 1'b0) begin
         err_cnt++; $display("FAIL rmid_drop: got req %b busy %b ready %b expected 0/0/0", mem_req, cpu_busy, cpu_ready); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (cpu_ready || cpu_busy) seen_ready++;
      end
      vec_cnt++; if (seen_ready !== 0) begin err_cnt++; $display("FAIL rmid_quiet: got %0d active cycles expected 0", seen_ready); end
      run_access(1'b0, 32'h180, 32'h0, 1, 32'h00000077);
      vec_cnt++; if (r_lat !== 4 || r_rdata !== 32'h00000077 || r_err !== 1'b0) begin
         err_cnt++; $display("FAIL rmid_reload: got lat %0d data %h err %b expected 4/00000077/0", r_lat, r_rdata, r_err); end
   endtask

`ifdef CACHE_PERF_CNT_EN
   task automatic test_perf();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      vec_cnt++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
         err_cnt++; $display("FAIL perf_rst: got %0d/%0d expected 0/0", hit_count, miss_count); end
      run_access(1'b0, 32'h80, 32'h0, 1, 32'h0);
      run_access(1'b0, 32'h200, 32'h0, 1, 32'h22222222);
      run_access(1'b0, 32'h200, 32'h0, 1, 32'h0);
      run_access(1'b1, 32'h240, 32'h44444444, 1, 32'h0);
      vec_cnt++; if (hit_count !== 32'd2) begin err_cnt++; $display("FAIL perf_hits: got %0d expected 2", hit_count); end
      vec_cnt++; if (miss_count !== 32'd2) begin err_cnt++; $display("FAIL perf_misses: got %0d expected 2", miss_count); end
   endtask
`endif

   initial begin
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0; cl_en = 1'b0;
      rst_n = 1'b1;
      test_reset();
      test_load_hit();
      test_load_miss();
      test_store();
      test_timeout();
      test_ack_at_limit();
      test_misc();
      test_reset_mid();
`ifdef CACHE_PERF_CNT_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
